mem_copy_engine: RTL and testbench

- Initiator-side master for the single-port data memory (combinational read, active-low write enable, write committed on the clock falling edge, word addressed).
- Performs word-block copy (source → destination) or constant fill for the ARM calculator datapath, e.g. clearing or moving operand buffers while the core waits.
- Software-style command handshake on one side; drives the memory address/data/write-enable pins on the other.

---
 rtl/mem_copy_engine.sv | 144 ++++++++++++++
 tb/tb_mem_copy_engine.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_engine.sv
// Word-block copy / constant-fill master for a single-port data memory.
// Memory pins are driven straight from flops so they stay stable across the falling-edge write.
module mem_copy_engine #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned LEN_W  = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              fill_i,
  input  logic [ADDR_W-1:0] src_addr_i,
  input  logic [ADDR_W-1:0] dst_addr_i,
  input  logic [LEN_W-1:0]  length_i,
  input  logic [31:0]       fill_value_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              aborted_o,
  output logic [LEN_W-1:0]  words_done_o,
  output logic [31:0]       mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              mem_we_n_o,
  input  logic [31:0]       mem_rdata_i
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e              state_q;
  logic                fill_q;
  logic [ADDR_W-1:0]   src_q;
  logic [ADDR_W-1:0]   dst_q;
  logic [LEN_W-1:0]    remain_q;
  logic [LEN_W-1:0]    words_done_q;
  logic                aborted_q;
  logic                busy_q;
  logic                done_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic                we_n_q;

  logic [ADDR_W-1:0]   src_inc;
  logic [ADDR_W-1:0]   dst_inc;
  logic                last_word;

  // Pointer increments wrap naturally at 2^ADDR_W.
  assign src_inc   = src_q + ADDR_W'(1);
  assign dst_inc   = dst_q + ADDR_W'(1);
  assign last_word = (remain_q == LEN_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      fill_q       <= 1'b0;
      src_q        <= '0;
      dst_q        <= '0;
      remain_q     <= '0;
      words_done_q <= '0;
      aborted_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_n_q       <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start_i) begin
            src_q        <= src_addr_i;
            dst_q        <= dst_addr_i;
            remain_q     <= length_i;
            fill_q       <= fill_i;
            words_done_q <= '0;
            aborted_q    <= 1'b0;
            if (length_i == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else if (fill_i) begin
              state_q <= StWrite;
              busy_q  <= 1'b1;
              addr_q  <= dst_addr_i;
              wdata_q <= fill_value_i;
              we_n_q  <= 1'b0;
            end else begin
              state_q <= StRead;
              busy_q  <= 1'b1;
              addr_q  <= src_addr_i;
              we_n_q  <= 1'b1;
            end
          end
        end
        StRead: begin
          if (abort_i) begin
            state_q   <= StDone;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            aborted_q <= 1'b1;
          end else begin
            state_q <= StWrite;
            addr_q  <= dst_q;
            wdata_q <= mem_rdata_i;
            we_n_q  <= 1'b0;
          end
        end
        StWrite: begin
          // The write in this cycle has already committed on the falling edge.
          words_done_q <= words_done_q + LEN_W'(1);
          src_q        <= src_inc;
          dst_q        <= dst_inc;
          remain_q     <= remain_q - LEN_W'(1);
          if (abort_i || last_word) begin
            state_q   <= StDone;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            aborted_q <= abort_i;
            we_n_q    <= 1'b1;
          end else if (fill_q) begin
            addr_q <= dst_inc;
            we_n_q <= 1'b0;
          end else begin
            state_q <= StRead;
            addr_q  <= src_inc;
            we_n_q  <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign aborted_o    = aborted_q;
  assign words_done_o = words_done_q;
  assign mem_addr_o   = 32'(addr_q);
  assign mem_wdata_o  = wdata_q;
  assign mem_we_n_o   = we_n_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: table of directed transfers, hand sequences for reset/overlap,
// and random transfers checked against a word-level memory model.
module tb_mem_copy_engine;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic        fill_i;
  logic [9:0]  src_addr_i;
  logic [9:0]  dst_addr_i;
  logic [10:0] length_i;
  logic [31:0] fill_value_i;
  logic        abort_i;
  logic        busy_o;
  logic        done_o;
  logic        aborted_o;
  logic [10:0] words_done_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_we_n_o;
  logic [31:0] mem_rdata_i;

  logic [31:0] mem [0:1023];
  logic [31:0] exp_mem [0:1023];

  logic        init_req;
  logic        pl_en;
  logic [9:0]  pl_addr;
  logic [31:0] pl_data;

  int compared;
  int mismatched;

  typedef struct {
    string       name;
    logic        fill;
    logic [9:0]  src;
    logic [9:0]  dst;
    logic [10:0] len;
    logic [31:0] val;
    int          ab;        // cycle after start in which abort is high (0 = never)
    int          bs;        // cycle after start in which a stray start is driven (0 = never)
    int          exp_words;
    logic        exp_ab;
    int          exp_done;  // cycle after start in which done is high
  } vec_t;

  mem_copy_engine #(
    .ADDR_W(10),
    .LEN_W (11)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .fill_i      (fill_i),
    .src_addr_i  (src_addr_i),
    .dst_addr_i  (dst_addr_i),
    .length_i    (length_i),
    .fill_value_i(fill_value_i),
    .abort_i     (abort_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .aborted_o   (aborted_o),
    .words_done_o(words_done_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_we_n_o  (mem_we_n_o),
    .mem_rdata_i (mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int i);
    return 32'h5A000000 ^ (32'(i) * 32'h9E3779B1);
  endfunction

  // Memory: combinational read, write on falling edge when we_n is low.
  assign mem_rdata_i = mem[mem_addr_o[9:0]];
  always @(negedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 1024; i++) mem[i] = init_word(i);
    end else if (pl_en) begin
      mem[pl_addr] = pl_data;
    end
    if (!mem_we_n_o) mem[mem_addr_o[9:0]] = mem_wdata_o;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    compared++;
    if (act !== want) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    exp_mem[a] = d;
    #1 pl_en = 1'b0;
  endtask

  task automatic mem_compare(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      if (mem[i] !== exp_mem[i]) begin
        if (bad == 0) $display("  %s: first differing word %0d got 0x%0h want 0x%0h",
                               name, i, mem[i], exp_mem[i]);
        bad++;
      end
    end
    chk({name, "_mem"}, 32'(bad), 32'd0);
  endtask

  function automatic vec_t mk(string name, logic fill, int src, int dst, int len,
                              logic [31:0] val, int ab, int bs, int words, logic abd, int dn);
    vec_t v;
    v.name = name; v.fill = fill; v.src = 10'(src); v.dst = 10'(dst); v.len = 11'(len);
    v.val = val; v.ab = ab; v.bs = bs; v.exp_words = words; v.exp_ab = abd; v.exp_done = dn;
    return v;
  endfunction

  // Transfer outcome from the command alone: copy spends two cycles per word, fill one.
  function automatic vec_t model(vec_t v);
    int acc;
    acc = v.fill ? int'(v.len) : 2 * int'(v.len);
    if (v.len == 0) begin
      v.exp_words = 0; v.exp_ab = 1'b0; v.exp_done = 1;
    end else if (v.ab != 0 && v.ab <= acc) begin
      v.exp_words = v.fill ? v.ab : v.ab / 2;
      v.exp_ab    = 1'b1;
      v.exp_done  = v.ab + 1;
    end else begin
      v.exp_words = int'(v.len); v.exp_ab = 1'b0; v.exp_done = acc + 1;
    end
    return v;
  endfunction

  task automatic run_xfer(input vec_t v);
    int c, done_cycle, we_low, busy_cnt, wr_bad, first_we, last_we, extra;
    logic [9:0] widx;
    @(negedge clk);
    fill_i = v.fill; src_addr_i = v.src; dst_addr_i = v.dst; length_i = v.len;
    fill_value_i = v.val; start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    // Scramble command inputs: the engine must work from its latched copy.
    src_addr_i = 10'($urandom); dst_addr_i = 10'($urandom); length_i = 11'($urandom);
    fill_i = ~v.fill; fill_value_i = $urandom;
    c = 1; done_cycle = 0; we_low = 0; busy_cnt = 0; wr_bad = 0; first_we = 0; last_we = 0;
    while (c <= 1100) begin
      if (done_o) begin
        done_cycle = c;
        break;
      end
      if (busy_o) busy_cnt++;
      if (!mem_we_n_o) begin
        widx = v.dst + 10'(we_low);
        if (mem_addr_o !== {22'd0, widx}) wr_bad++;
        if (v.fill && mem_wdata_o !== v.val) wr_bad++;
        if (we_low == 0) first_we = c;
        last_we = c;
        we_low++;
      end
      abort_i = (c == v.ab);
      start_i = (c == v.bs);
      @(posedge clk);
      #1;
      c++;
    end
    abort_i = 1'b0;
    start_i = 1'b0;
    chk({v.name, "_done_cycle"}, 32'(done_cycle), 32'(v.exp_done));
    chk({v.name, "_words_done"}, 32'(words_done_o), 32'(v.exp_words));
    chk({v.name, "_aborted"}, 32'(aborted_o), 32'(v.exp_ab));
    chk({v.name, "_busy_at_done"}, 32'(busy_o), 32'd0);
    chk({v.name, "_busy_cycles"}, 32'(busy_cnt), 32'(v.exp_done - 1));
    chk({v.name, "_we_cycles"}, 32'(we_low), 32'(v.exp_words));
    chk({v.name, "_wr_addr_data"}, 32'(wr_bad), 32'd0);
    if (v.fill && we_low > 0) chk({v.name, "_we_span"}, 32'(last_we - first_we + 1), 32'(we_low));
    extra = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      if (done_o || busy_o || !mem_we_n_o) extra++;
    end
    chk({v.name, "_quiet_after"}, 32'(extra), 32'd0);
    for (int i = 0; i < v.exp_words; i++) begin
      exp_mem[10'(v.dst + 10'(i))] = v.fill ? v.val : exp_mem[10'(v.src + 10'(i))];
    end
    mem_compare(v.name);
  endtask

  vec_t tbl[9];
  vec_t rv;

  initial begin
    compared = 0; mismatched = 0;
    rst_n = 1'b0; start_i = 1'b0; fill_i = 1'b0; src_addr_i = '0; dst_addr_i = '0;
    length_i = '0; fill_value_i = '0; abort_i = 1'b0;
    init_req = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    for (int i = 0; i < 1024; i++) exp_mem[i] = init_word(i);
    @(negedge clk);
    #1 init_req = 1'b0;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_aborted", 32'(aborted_o), 32'd0);
    chk("rst_words", 32'(words_done_o), 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_wdata", mem_wdata_o, 32'd0);
    chk("rst_we_n", 32'(mem_we_n_o), 32'd1);
    rst_n = 1'b1;

    tbl[0] = mk("copy4",     1'b0,    0, 100,    4, 32'h0,        0, 0,    4, 1'b0,    9);
    tbl[1] = mk("fill3",     1'b1,    0, 500,    3, 32'hDEADBEEF, 0, 0,    3, 1'b0,    4);
    tbl[2] = mk("copy_wrap", 1'b0, 1022,  10,    4, 32'h0,        0, 0,    4, 1'b0,    9);
    tbl[3] = mk("len0",      1'b0,    5, 600,    0, 32'h0,        0, 0,    0, 1'b0,    1);
    tbl[4] = mk("ab_write2", 1'b0,   20, 300,    8, 32'h0,        4, 0,    2, 1'b1,    5);
    tbl[5] = mk("ab_read3",  1'b0,   40, 320,    8, 32'h0,        5, 0,    2, 1'b1,    6);
    tbl[6] = mk("ab_last",   1'b0,   60, 340,    2, 32'h0,        4, 0,    2, 1'b1,    5);
    tbl[7] = mk("fill_ab",   1'b1,    0, 700,    6, 32'h12345678, 3, 0,    3, 1'b1,    4);
    tbl[8] = mk("fill_all",  1'b1,    0, 900, 1024, 32'h0BADF00D, 0, 0, 1024, 1'b0, 1025);

    preload(10'd0, 32'h11); preload(10'd1, 32'h22); preload(10'd2, 32'h33); preload(10'd3, 32'h44);
    for (int t = 0; t < 9; t++) begin
      run_xfer(tbl[t]);
      if (t == 0) begin
        for (int i = 0; i < 4; i++) chk("copy4_word", mem[100 + i], 32'h11 * 32'(i + 1));
      end
    end

    // Reset during the second write of a fill: that write must not land.
    @(negedge clk);
    fill_i = 1'b1; dst_addr_i = 10'd200; length_i = 11'd5; fill_value_i = 32'hCAFEF00D;
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_we_before", 32'(mem_we_n_o), 32'd0);
    chk("midrst_addr_before", mem_addr_o, 32'd201);
    rst_n = 1'b0;
    #1;
    chk("midrst_we_n", 32'(mem_we_n_o), 32'd1);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_done", 32'(done_o), 32'd0);
    chk("midrst_words", 32'(words_done_o), 32'd0);
    chk("midrst_addr", mem_addr_o, 32'd0);
    chk("midrst_wdata", mem_wdata_o, 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    exp_mem[200] = 32'hCAFEF00D;
    mem_compare("midrst");

    // Overlapping copy replicates mem[0]; a start while busy is ignored.
    preload(10'd0, 32'hA);
    run_xfer(mk("overlap", 1'b0, 0, 1, 4, 32'h0, 0, 3, 4, 1'b0, 9));
    for (int i = 1; i <= 4; i++) chk("overlap_word", mem[i], 32'hA);

    for (int r = 0; r < 30; r++) begin
      rv.name = "rand";
      rv.fill = 1'($urandom);
      rv.src  = 10'($urandom);
      rv.dst  = 10'($urandom);
      rv.len  = 11'($urandom_range(0, 12));
      rv.val  = $urandom;
      rv.ab   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 26)) : 0;
      rv.bs   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 8)) : 0;
      rv = model(rv);
      run_xfer(rv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
